// File: rtl/memoria_config_qos.sv
// memoria_config_qos
//   Double-buffered QoS configuration memory. Software writes land in a shadow
//   bank; a commit copies shadow to active only on an arbitration-table wrap so
//   the arbiter never observes a partially updated table.
//
//   Ports:
//     clk, rst          clock (posedge), asynchronous active-high reset
//     enb               block enable; low freezes all configuration state
//     wr_valid/wr_ready write handshake (wr_ready is registered)
//     wr_addr           [7:6] region (00 table, 01 weight, 10 alto, 11 bajo), [5:0] index
//     wr_data           write value, LSBs used per region
//     wr_error          one-cycle pulse after a rejected (consumed) write
//     commit            request shadow->active copy
//     table_wrap        arbiter is at the last table entry this cycle
//     commit_pending    commit waiting for table_wrap
//     config_valid      sticky, set by the first completed commit
//     selecciones_out, pesos_out, umbrales_alto_out, umbrales_bajo_out
//                       packed active bank
//
//   Optional feature macro QOS_CFG_READBACK_EN adds rd_addr/rd_data: registered
//   readback of the active bank (1-cycle latency, independent of enb).
module memoria_config_qos #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned TABLE_SIZE     = 8,
  parameter int unsigned MAX_WEIGHT     = 64,
  parameter int unsigned MAX_MAG_UMBRAL = 8,
  parameter int unsigned DATA_BITS      = 8,
  localparam int unsigned SEL_W         = $clog2(QUEUE_QUANTITY),
  localparam int unsigned WEIGHT_W      = $clog2(MAX_WEIGHT + 1),
  localparam int unsigned UMB_W         = $clog2(MAX_MAG_UMBRAL + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enb,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [7:0]                         wr_addr,
  input  logic [DATA_BITS-1:0]               wr_data,
  output logic                               wr_error,
  input  logic                               commit,
  input  logic                               table_wrap,
  output logic                               commit_pending,
  output logic                               config_valid,
  output logic [TABLE_SIZE*SEL_W-1:0]        selecciones_out,
  output logic [QUEUE_QUANTITY*WEIGHT_W-1:0] pesos_out,
  output logic [QUEUE_QUANTITY*UMB_W-1:0]    umbrales_alto_out,
  output logic [QUEUE_QUANTITY*UMB_W-1:0]    umbrales_bajo_out
`ifdef QOS_CFG_READBACK_EN
  ,
  input  logic [7:0]                         rd_addr,
  output logic [DATA_BITS-1:0]               rd_data
`endif
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]    sel_sh_q  [TABLE_SIZE],     sel_sh_d  [TABLE_SIZE];
  logic [SEL_W-1:0]    sel_act_q [TABLE_SIZE],     sel_act_d [TABLE_SIZE];
  logic [WEIGHT_W-1:0] w_sh_q    [QUEUE_QUANTITY], w_sh_d    [QUEUE_QUANTITY];
  logic [WEIGHT_W-1:0] w_act_q   [QUEUE_QUANTITY], w_act_d   [QUEUE_QUANTITY];
  logic [UMB_W-1:0]    alto_sh_q [QUEUE_QUANTITY], alto_sh_d [QUEUE_QUANTITY];
  logic [UMB_W-1:0]    alto_act_q[QUEUE_QUANTITY], alto_act_d[QUEUE_QUANTITY];
  logic [UMB_W-1:0]    bajo_sh_q [QUEUE_QUANTITY], bajo_sh_d [QUEUE_QUANTITY];
  logic [UMB_W-1:0]    bajo_act_q[QUEUE_QUANTITY], bajo_act_d[QUEUE_QUANTITY];

  logic wr_ready_q, wr_ready_d;
  logic wr_error_q, wr_error_d;
  logic config_valid_q, config_valid_d;

  logic [31:0] wr_idx, wr_val;
  logic        wr_accept, wr_ok, do_copy;

  assign wr_idx    = 32'(wr_addr[5:0]);
  assign wr_val    = 32'(wr_data);
  assign wr_accept = enb & wr_valid & wr_ready_q;

  always_comb begin
    wr_ok = 1'b0;
    case (wr_addr[7:6])
      2'b00:   wr_ok = (wr_idx < TABLE_SIZE) && (wr_val < QUEUE_QUANTITY);
      2'b01:   wr_ok = (wr_idx < QUEUE_QUANTITY) && (wr_val >= 32'd1) && (wr_val <= MAX_WEIGHT);
      default: wr_ok = (wr_idx < QUEUE_QUANTITY) && (wr_val <= MAX_MAG_UMBRAL);
    endcase
  end

  always_comb begin
    state_d        = state_q;
    sel_sh_d       = sel_sh_q;
    w_sh_d         = w_sh_q;
    alto_sh_d      = alto_sh_q;
    bajo_sh_d      = bajo_sh_q;
    sel_act_d      = sel_act_q;
    w_act_d        = w_act_q;
    alto_act_d     = alto_act_q;
    bajo_act_d     = bajo_act_q;
    config_valid_d = config_valid_q;
    wr_error_d     = 1'b0;
    do_copy        = 1'b0;

    if (wr_accept) begin
      if (wr_ok) begin
        for (int unsigned i = 0; i < TABLE_SIZE; i++)
          if (wr_addr[7:6] == 2'b00 && wr_idx == i) sel_sh_d[i] = wr_data[SEL_W-1:0];
        for (int unsigned q = 0; q < QUEUE_QUANTITY; q++) begin
          if (wr_addr[7:6] == 2'b01 && wr_idx == q) w_sh_d[q]    = wr_data[WEIGHT_W-1:0];
          if (wr_addr[7:6] == 2'b10 && wr_idx == q) alto_sh_d[q] = wr_data[UMB_W-1:0];
          if (wr_addr[7:6] == 2'b11 && wr_idx == q) bajo_sh_d[q] = wr_data[UMB_W-1:0];
        end
      end else begin
        wr_error_d = 1'b1;
      end
    end

    if (enb) begin
      unique case (state_q)
        IDLE: begin
          if (commit) begin
            if (table_wrap) do_copy = 1'b1;
            else            state_d = PENDING;
          end
        end
        PENDING: begin
          if (table_wrap) begin
            do_copy = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end

    // Copy from the post-write shadow so a same-cycle accepted write is included.
    if (do_copy) begin
      sel_act_d      = sel_sh_d;
      w_act_d        = w_sh_d;
      alto_act_d     = alto_sh_d;
      bajo_act_d     = bajo_sh_d;
      config_valid_d = 1'b1;
    end

    // Looks at the next state so no write can slip in on the first PENDING cycle.
    wr_ready_d = enb & (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ready_q     <= 1'b0;
      wr_error_q     <= 1'b0;
      config_valid_q <= 1'b0;
      for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
        sel_sh_q[i]  <= SEL_W'(i % QUEUE_QUANTITY);
        sel_act_q[i] <= SEL_W'(i % QUEUE_QUANTITY);
      end
      for (int unsigned q = 0; q < QUEUE_QUANTITY; q++) begin
        w_sh_q[q]     <= WEIGHT_W'(1);
        w_act_q[q]    <= WEIGHT_W'(1);
        alto_sh_q[q]  <= UMB_W'(MAX_MAG_UMBRAL);
        alto_act_q[q] <= UMB_W'(MAX_MAG_UMBRAL);
        bajo_sh_q[q]  <= '0;
        bajo_act_q[q] <= '0;
      end
    end else begin
      state_q        <= state_d;
      wr_ready_q     <= wr_ready_d;
      wr_error_q     <= wr_error_d;
      config_valid_q <= config_valid_d;
      sel_sh_q       <= sel_sh_d;
      sel_act_q      <= sel_act_d;
      w_sh_q         <= w_sh_d;
      w_act_q        <= w_act_d;
      alto_sh_q      <= alto_sh_d;
      alto_act_q     <= alto_act_d;
      bajo_sh_q      <= bajo_sh_d;
      bajo_act_q     <= bajo_act_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign wr_error       = wr_error_q;
  assign commit_pending = (state_q == PENDING);
  assign config_valid   = config_valid_q;

  always_comb begin
    selecciones_out   = '0;
    pesos_out         = '0;
    umbrales_alto_out = '0;
    umbrales_bajo_out = '0;
    for (int unsigned i = 0; i < TABLE_SIZE; i++)
      selecciones_out[i*SEL_W +: SEL_W] = sel_act_q[i];
    for (int unsigned q = 0; q < QUEUE_QUANTITY; q++) begin
      pesos_out[q*WEIGHT_W +: WEIGHT_W] = w_act_q[q];
      umbrales_alto_out[q*UMB_W +: UMB_W] = alto_act_q[q];
      umbrales_bajo_out[q*UMB_W +: UMB_W] = bajo_act_q[q];
    end
  end

`ifdef QOS_CFG_READBACK_EN
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [31:0]          rd_idx;

  assign rd_idx = 32'(rd_addr[5:0]);

  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < TABLE_SIZE; i++)
      if (rd_addr[7:6] == 2'b00 && rd_idx == i) rd_data_d = DATA_BITS'(sel_act_q[i]);
    for (int unsigned q = 0; q < QUEUE_QUANTITY; q++) begin
      if (rd_addr[7:6] == 2'b01 && rd_idx == q) rd_data_d = DATA_BITS'(w_act_q[q]);
      if (rd_addr[7:6] == 2'b10 && rd_idx == q) rd_data_d = DATA_BITS'(alto_act_q[q]);
      if (rd_addr[7:6] == 2'b11 && rd_idx == q) rd_data_d = DATA_BITS'(bajo_act_q[q]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_memoria_config_qos.sv
module tb_memoria_config_qos;

  logic        clk = 1'b0;
  logic        rst, enb, wr_valid, wr_ready, wr_error;
  logic [7:0]  wr_addr, wr_data;
  logic        commit, table_wrap, commit_pending, config_valid;
  logic [15:0] sel_o;
  logic [27:0] pesos_o;
  logic [15:0] alto_o, bajo_o;
`ifdef QOS_CFG_READBACK_EN
  logic [7:0]  rd_addr, rd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memoria_config_qos #(
    .QUEUE_QUANTITY(4), .TABLE_SIZE(8), .MAX_WEIGHT(64), .MAX_MAG_UMBRAL(8), .DATA_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_error(wr_error), .commit(commit), .table_wrap(table_wrap),
    .commit_pending(commit_pending), .config_valid(config_valid),
    .selecciones_out(sel_o), .pesos_out(pesos_o),
    .umbrales_alto_out(alto_o), .umbrales_bajo_out(bajo_o)
`ifdef QOS_CFG_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  // Reference model: shadow (m_*) and active (a_*) banks as plain integers.
  int m_sel[8], a_sel[8];
  int m_w[4], a_w[4], m_alto[4], a_alto[4], m_bajo[4], a_bajo[4];
  bit m_pend, m_cv, m_ready, m_err;
`ifdef QOS_CFG_READBACK_EN
  int m_rd;

  function automatic int lookup(input logic [7:0] ra);
    int idx;
    idx = int'(ra[5:0]);
    case (ra[7:6])
      2'b00:   return (idx < 8) ? a_sel[idx] : 0;
      2'b01:   return (idx < 4) ? a_w[idx] : 0;
      2'b10:   return (idx < 4) ? a_alto[idx] : 0;
      default: return (idx < 4) ? a_bajo[idx] : 0;
    endcase
  endfunction
`endif

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_sel[i] = i % 4; a_sel[i] = i % 4; end
    for (int q = 0; q < 4; q++) begin
      m_w[q] = 1; a_w[q] = 1; m_alto[q] = 8; a_alto[q] = 8; m_bajo[q] = 0; a_bajo[q] = 0;
    end
    m_pend = 0; m_cv = 0; m_ready = 0; m_err = 0;
`ifdef QOS_CFG_READBACK_EN
    m_rd = 0;
`endif
  endtask

  task automatic model_step(input bit e, v, input logic [7:0] a, d, input bit c, w);
    int idx, val;
    bit ok, err, copy;
`ifdef QOS_CFG_READBACK_EN
    m_rd = lookup(rd_addr);
`endif
    err = 0; copy = 0;
    idx = int'(a[5:0]); val = int'(d);
    if (e) begin
      if (v && m_ready) begin
        case (a[7:6])
          2'b00:   ok = idx < 8 && val < 4;
          2'b01:   ok = idx < 4 && val >= 1 && val <= 64;
          default: ok = idx < 4 && val <= 8;
        endcase
        if (!ok) err = 1;
        else case (a[7:6])
          2'b00:   m_sel[idx] = val;
          2'b01:   m_w[idx] = val;
          2'b10:   m_alto[idx] = val;
          default: m_bajo[idx] = val;
        endcase
      end
      if (!m_pend) begin
        if (c && w) copy = 1;
        else if (c) m_pend = 1;
      end else if (w) begin
        copy = 1; m_pend = 0;
      end
    end
    if (copy) begin
      a_sel = m_sel; a_w = m_w; a_alto = m_alto; a_bajo = m_bajo; m_cv = 1;
    end
    m_err = err;
    m_ready = e && !m_pend;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] es, ep, eh, el;
    es = '0; ep = '0; eh = '0; el = '0;
    for (int i = 0; i < 8; i++) es |= 64'(a_sel[i]) << (2 * i);
    for (int q = 0; q < 4; q++) begin
      ep |= 64'(a_w[q]) << (7 * q);
      eh |= 64'(a_alto[q]) << (4 * q);
      el |= 64'(a_bajo[q]) << (4 * q);
    end
    chk("wr_ready", 64'(wr_ready), 64'(m_ready));
    chk("wr_error", 64'(wr_error), 64'(m_err));
    chk("commit_pending", 64'(commit_pending), 64'(m_pend));
    chk("config_valid", 64'(config_valid), 64'(m_cv));
    chk("selecciones", 64'(sel_o), es);
    chk("pesos", 64'(pesos_o), ep);
    chk("alto", 64'(alto_o), eh);
    chk("bajo", 64'(bajo_o), el);
`ifdef QOS_CFG_READBACK_EN
    chk("rd_data", 64'(rd_data), 64'(m_rd));
`endif
  endtask

  // Inputs applied 1 time unit after an edge; outputs checked 1 unit after the next edge.
  task automatic cycle(input bit e, v, input logic [7:0] a, d, input bit c, w);
    enb = e; wr_valid = v; wr_addr = a; wr_data = d; commit = c; table_wrap = w;
    @(posedge clk);
    model_step(e, v, a, d, c, w);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1; enb = 0; wr_valid = 0; commit = 0; table_wrap = 0; wr_addr = '0; wr_data = '0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    bit e, v; logic [7:0] a, d; bit c, w;
    bit x_ready, x_err, x_pend, x_cv; logic [15:0] x_sel;
  } vec_t;

  vec_t tbl[11];

  localparam logic [27:0] PESOS_DEF = 28'd2113665;  // all weights 1
  localparam logic [27:0] PESOS_Q1  = 28'd2121729;  // weight[1] = 64

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 0, 8'h00, 8'd0,  0, 0, 1, 0, 0, 0, 16'hE4E4};
    tbl[1]  = '{1, 1, 8'h03, 8'd2,  0, 0, 1, 0, 0, 0, 16'hE4E4};
    tbl[2]  = '{1, 0, 8'h00, 8'd0,  1, 0, 0, 0, 1, 0, 16'hE4E4};
    tbl[3]  = '{1, 0, 8'h00, 8'd0,  0, 0, 0, 0, 1, 0, 16'hE4E4};
    tbl[4]  = '{1, 0, 8'h00, 8'd0,  1, 0, 0, 0, 1, 0, 16'hE4E4};
    tbl[5]  = '{1, 0, 8'h00, 8'd0,  0, 1, 1, 0, 0, 1, 16'hE4A4};
    tbl[6]  = '{1, 1, 8'h41, 8'd0,  0, 0, 1, 1, 0, 1, 16'hE4A4};
    tbl[7]  = '{1, 1, 8'h41, 8'd65, 0, 0, 1, 1, 0, 1, 16'hE4A4};
    tbl[8]  = '{1, 1, 8'h08, 8'd1,  0, 0, 1, 1, 0, 1, 16'hE4A4};
    tbl[9]  = '{1, 1, 8'h41, 8'd64, 0, 0, 1, 0, 0, 1, 16'hE4A4};
    tbl[10] = '{1, 0, 8'h00, 8'd0,  0, 0, 1, 0, 0, 1, 16'hE4A4};

`ifdef QOS_CFG_READBACK_EN
    rd_addr = 8'h00;
`endif
    do_reset();
    chk("reset_sel", 64'(sel_o), 64'h0000_E4E4);
    chk("reset_pesos", 64'(pesos_o), 64'(PESOS_DEF));
    chk("reset_alto", 64'(alto_o), 64'h8888);
    chk("reset_ready", 64'(wr_ready), 64'd0);

    foreach (tbl[k]) begin
      cycle(tbl[k].e, tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].c, tbl[k].w);
      chk($sformatf("tbl%0d_ready", k), 64'(wr_ready), 64'(tbl[k].x_ready));
      chk($sformatf("tbl%0d_err", k), 64'(wr_error), 64'(tbl[k].x_err));
      chk($sformatf("tbl%0d_pend", k), 64'(commit_pending), 64'(tbl[k].x_pend));
      chk($sformatf("tbl%0d_cv", k), 64'(config_valid), 64'(tbl[k].x_cv));
      chk($sformatf("tbl%0d_sel", k), 64'(sel_o), 64'(tbl[k].x_sel));
      chk($sformatf("tbl%0d_pesos", k), 64'(pesos_o), 64'(PESOS_DEF));
    end

    // Write + commit + wrap in one cycle: includes both the new alto and the pending weight.
    cycle(1, 1, 8'h82, 8'd5, 1, 1);
    chk("same_cycle_alto", 64'(alto_o), 64'h8588);
    chk("same_cycle_pesos", 64'(pesos_o), 64'(PESOS_Q1));
    chk("same_cycle_pend", 64'(commit_pending), 64'd0);
    chk("same_cycle_ready", 64'(wr_ready), 64'd1);

    // Reset while PENDING aborts the commit and restores defaults.
    cycle(1, 1, 8'h05, 8'd1, 0, 0);
    cycle(1, 0, 8'h00, 8'd0, 1, 0);
    chk("pend_before_rst", 64'(commit_pending), 64'd1);
    do_reset();
    cycle(1, 0, 8'h00, 8'd0, 0, 0);
    chk("rst_pend", 64'(commit_pending), 64'd0);
    chk("rst_sel", 64'(sel_o), 64'h0000_E4E4);
    chk("rst_pesos", 64'(pesos_o), 64'(PESOS_DEF));
    chk("rst_alto", 64'(alto_o), 64'h8888);
    chk("rst_cv", 64'(config_valid), 64'd0);
    cycle(1, 0, 8'h00, 8'd0, 0, 1);
    chk("late_wrap_sel", 64'(sel_o), 64'h0000_E4E4);
    chk("late_wrap_cv", 64'(config_valid), 64'd0);

    // enb low: write, commit and wrap all ignored.
    cycle(1, 1, 8'hC1, 8'd3, 0, 0);
    cycle(0, 1, 8'h00, 8'd3, 1, 1);
    chk("enb0_cv", 64'(config_valid), 64'd0);
    chk("enb0_ready", 64'(wr_ready), 64'd0);
    chk("enb0_err", 64'(wr_error), 64'd0);
    cycle(1, 0, 8'h00, 8'd0, 1, 1);
    chk("commit_bajo", 64'(bajo_o), 64'h0030);
    chk("commit_sel", 64'(sel_o), 64'h0000_E4E4);
    chk("commit_cv", 64'(config_valid), 64'd1);
`ifdef QOS_CFG_READBACK_EN
    rd_addr = 8'hC1;
    cycle(1, 0, 8'h00, 8'd0, 0, 0);
    chk("rd_c1", 64'(rd_data), 64'd3);
    rd_addr = 8'h3F;
    cycle(1, 0, 8'h00, 8'd0, 0, 0);
    chk("rd_3f", 64'(rd_data), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit e, v, c, w;
      logic [7:0] a, d;
      if ($urandom_range(0, 249) == 0) do_reset();
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 1) == 1);
      a = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 9))};
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 66));
      c = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 4) == 0);
`ifdef QOS_CFG_READBACK_EN
      rd_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                            : {2'($urandom_range(0, 3)), 6'($urandom_range(0, 9))};
`endif
      cycle(e, v, a, d, c, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
